// File: rtl/instr_fetch_unit.sv
// Instruction fetch/sequencing for the non-pipelined core: holds the PC, fetches over req/ack, retires on ex_done.
// Latency: 3 edges per instruction with a same-cycle ack; unbounded stalls while waiting on imem_ack or ex_done.
module instr_fetch_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(32'h0000_0000)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    input  logic                jump,
    input  logic                branch,
    input  logic                alu_zero,
    input  logic                ex_done,
    output logic [31:0]         instr,
    output logic [5:0]          opcode,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic [31:0]         instr_count
);

    typedef enum logic [1:0] {IDLE, FETCH, DECODE, EXECUTE} state_t;

    state_t              state, state_nxt;
    logic                start_fetch, fetch_done, retire;
    logic [PC_WIDTH-1:0] next_pc, br_off;

    assign opcode   = instr[31:26];
    assign pc_plus4 = pc + PC_WIDTH'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (imem_ack) state_nxt = DECODE;
            DECODE:  state_nxt = EXECUTE;
            EXECUTE: if (ex_done) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_fetch = (state == IDLE);
        fetch_done  = (state == FETCH) && imem_ack;
        retire      = (state == EXECUTE) && ex_done;
    end

    // Control inputs only matter on the retire edge, so next_pc is consumed only there.
    assign br_off = {{(PC_WIDTH-18){instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[PC_WIDTH-1:28], instr[25:0], 2'b00};
        end else if (branch && alu_zero) begin
            next_pc = pc_plus4 + br_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            instr_count <= '0;
        end else begin
            if (start_fetch) begin
                imem_req  <= 1'b1;
                imem_addr <= pc;
            end
            if (fetch_done) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
                imem_req    <= 1'b0;
            end
            if (retire) begin
                pc          <= next_pc;
                imem_addr   <= next_pc;
                imem_req    <= 1'b1;
                instr_valid <= 1'b0;
                instr_count <= instr_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a next-PC / retire-count reference model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst1_n, rst2_n, ack, ex_done, jump, branch, alu_zero, sel;
    logic [31:0] rdata;

    logic        req1, req2, vld1, vld2;
    logic [31:0] addr1, addr2, ins1, ins2, pc1, pc2, pc4_1, pc4_2, cnt1, cnt2;
    logic [5:0]  opc1, opc2;

    logic        req, vld;
    logic [31:0] addr, ins, pc_cur, pc4, cnt;
    logic [5:0]  opc;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mpc, mcount;

    always #5 clk = ~clk;

    instr_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut1 (
        .clk(clk), .rst_n(rst1_n), .imem_req(req1), .imem_addr(addr1), .imem_ack(ack),
        .imem_rdata(rdata), .jump(jump), .branch(branch), .alu_zero(alu_zero), .ex_done(ex_done),
        .instr(ins1), .opcode(opc1), .instr_valid(vld1), .pc(pc1), .pc_plus4(pc4_1),
        .instr_count(cnt1)
    );

    instr_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h1000_0010)) dut2 (
        .clk(clk), .rst_n(rst2_n), .imem_req(req2), .imem_addr(addr2), .imem_ack(ack),
        .imem_rdata(rdata), .jump(jump), .branch(branch), .alu_zero(alu_zero), .ex_done(ex_done),
        .instr(ins2), .opcode(opc2), .instr_valid(vld2), .pc(pc2), .pc_plus4(pc4_2),
        .instr_count(cnt2)
    );

    assign req    = sel ? req2  : req1;
    assign addr   = sel ? addr2 : addr1;
    assign ins    = sel ? ins2  : ins1;
    assign opc    = sel ? opc2  : opc1;
    assign vld    = sel ? vld2  : vld1;
    assign pc_cur = sel ? pc2   : pc1;
    assign pc4    = sel ? pc4_2 : pc4_1;
    assign cnt    = sel ? cnt2  : cnt1;

    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic j, input logic b, input logic z);
        logic [31:0] p4;
        int          off;
        p4 = p + 32'd4;
        if (j) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        off = int'($signed(w[15:0]));
        if (b && z) return p4 + 32'(off * 4);
        return p4;
    endfunction

    // One complete instruction: fetch (with ack_wait stalls), decode, execute (ex_wait stalls), retire.
    task automatic run_instr(input logic [31:0] word, input int ack_wait, input int ex_wait,
                             input bit stray, input bit j, input bit b, input bit z, input bit pre);
        logic [31:0] exp;
        int n;
        n = 0;
        while (req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req !== 1'b1) begin
            $display("FAIL req_timeout got %b want 1", req);
            errors++;
            return;
        end
        checks++;
        if (addr !== mpc) begin $display("FAIL fetch_addr got %h want %h", addr, mpc); errors++; end
        checks++;
        if (pc_cur !== mpc) begin $display("FAIL fetch_pc got %h want %h", pc_cur, mpc); errors++; end
        for (int i = 0; i < ack_wait; i++) begin
            ack = 1'b0; ex_done = 1'($urandom); rdata = $urandom;
            @(negedge clk);
            checks++;
            if (req !== 1'b1 || addr !== mpc || vld !== 1'b0) begin
                $display("FAIL fetch_hold req %b addr %h vld %b want 1 %h 0", req, addr, vld, mpc);
                errors++;
            end
        end
        rdata = word; ack = 1'b1; ex_done = 1'($urandom);
        @(negedge clk);
        ack = stray; rdata = ~word; ex_done = 1'($urandom);
        checks++;
        if (ins !== word || vld !== 1'b1 || opc !== word[31:26]) begin
            $display("FAIL decode_instr got %h/%b/%h want %h/1/%h", ins, vld, opc, word, word[31:26]);
            errors++;
        end
        checks++;
        if (req !== 1'b0 || pc4 !== mpc + 32'd4) begin
            $display("FAIL decode_req_pc4 got %b/%h want 0/%h", req, pc4, mpc + 32'd4);
            errors++;
        end
        @(negedge clk);
        ack = 1'b0;
        if (pre) begin
            force dut1.instr_count = 32'hFFFF_FFFF;
            #1;
            release dut1.instr_count;
            mcount = 32'hFFFF_FFFF;
        end
        for (int i = 0; i < ex_wait; i++) begin
            ex_done = 1'b0; ack = stray; rdata = $urandom;
            jump = 1'($urandom); branch = 1'($urandom); alu_zero = 1'($urandom);
            @(negedge clk);
            checks++;
            if (req !== 1'b0 || cnt !== mcount || ins !== word) begin
                $display("FAIL exec_hold req %b cnt %h instr %h want 0 %h %h", req, cnt, ins, mcount, word);
                errors++;
            end
        end
        ack = 1'b0; jump = j; branch = b; alu_zero = z; ex_done = 1'b1;
        @(negedge clk);
        ex_done = 1'b0; jump = 1'($urandom); branch = 1'($urandom); alu_zero = 1'($urandom);
        exp    = ref_next(mpc, word, j, b, z);
        mcount = mcount + 32'd1;
        mpc    = exp;
        checks++;
        if (req !== 1'b1 || addr !== exp || pc_cur !== exp) begin
            $display("FAIL retire_pc req %b addr %h pc %h want 1 %h", req, addr, pc_cur, exp);
            errors++;
        end
        checks++;
        if (vld !== 1'b0 || cnt !== mcount) begin
            $display("FAIL retire_count vld %b cnt %h want 0 %h", vld, cnt, mcount);
            errors++;
        end
    endtask

    task automatic test_reset;
        rst1_n = 1'b0;
        #1;
        checks++;
        if (req !== 1'b0 || addr !== 32'h0 || pc_cur !== 32'h0 || pc4 !== 32'h4) begin
            $display("FAIL reset_pc req %b addr %h pc %h pc4 %h want 0 0 0 4", req, addr, pc_cur, pc4);
            errors++;
        end
        checks++;
        if (ins !== 32'h0 || vld !== 1'b0 || cnt !== 32'h0 || opc !== 6'h0) begin
            $display("FAIL reset_regs instr %h vld %b cnt %h opc %h want 0", ins, vld, cnt, opc);
            errors++;
        end
        @(negedge clk);
        rst1_n = 1'b1;
        mpc = 32'h0; mcount = 32'h0;
        @(negedge clk);
        checks++;
        if (req !== 1'b1 || addr !== 32'h0) begin
            $display("FAIL first_fetch req %b addr %h want 1 0", req, addr);
            errors++;
        end
    endtask

    task automatic test_sequential;
        for (int k = 0; k < 3; k++) begin
            run_instr($urandom & 32'h03FF_FFFF, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (addr !== 32'(4 * (k + 1)) || cnt !== 32'(k + 1)) begin
                $display("FAIL seq_step addr %h cnt %0d want %h %0d", addr, cnt, 4 * (k + 1), k + 1);
                errors++;
            end
        end
    endtask

    task automatic test_branch;
        for (int k = 0; k < 8 && mpc != 32'h20; k++) run_instr($urandom, 0, 0, 0, 0, 0, 0, 0);
        run_instr(32'h1022_FFFC, 0, 0, 0, 0, 1, 1, 0);
        checks++;
        if (pc_cur !== 32'h14) begin $display("FAIL beq_taken pc %h want 14", pc_cur); errors++; end
        for (int k = 0; k < 8 && mpc != 32'h20; k++) run_instr($urandom, 0, 0, 0, 0, 0, 0, 0);
        run_instr(32'h1022_FFFC, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (pc_cur !== 32'h24) begin $display("FAIL beq_not_taken pc %h want 24", pc_cur); errors++; end
    endtask

    task automatic test_wait_states;
        run_instr($urandom, 5, 3, 1, 0, 0, 0, 0);
    endtask

    task automatic test_pc_wrap;
        logic [15:0] imm;
        imm = 16'(-(int'(mpc) + 8) / 4);
        run_instr({6'h04, 10'h0, imm}, 0, 0, 0, 0, 1, 1, 0);
        checks++;
        if (pc_cur !== 32'hFFFF_FFFC) begin $display("FAIL neg_branch pc %h want fffffffc", pc_cur); errors++; end
        run_instr($urandom, 1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (addr !== 32'h0) begin $display("FAIL pc_wrap addr %h want 0", addr); errors++; end
    endtask

    task automatic test_random;
        for (int k = 0; k < 30; k++) begin
            run_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom), 0);
        end
    endtask

    task automatic test_count_wrap;
        run_instr($urandom, 0, 1, 0, 0, 0, 0, 1);
        checks++;
        if (cnt !== 32'h0) begin $display("FAIL count_wrap cnt %h want 0", cnt); errors++; end
    endtask

    task automatic test_reset_mid_fetch;
        ack = 1'b0;
        repeat (2) @(negedge clk);
        rst1_n = 1'b0;
        #1;
        checks++;
        if (req !== 1'b0 || pc_cur !== 32'h0 || vld !== 1'b0 || cnt !== 32'h0 || addr !== 32'h0) begin
            $display("FAIL mid_reset req %b pc %h vld %b cnt %h addr %h want 0", req, pc_cur, vld, cnt, addr);
            errors++;
        end
        ack = 1'b1; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst1_n = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (req !== 1'b1 || addr !== 32'h0 || ins !== 32'h0 || vld !== 1'b0) begin
            $display("FAIL post_reset_fetch req %b addr %h instr %h vld %b want 1 0 0 0", req, addr, ins, vld);
            errors++;
        end
        mpc = 32'h0; mcount = 32'h0;
        run_instr($urandom, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_jump;
        rst1_n = 1'b0;
        sel = 1'b1;
        #1;
        checks++;
        if (pc_cur !== 32'h1000_0010 || addr !== 32'h1000_0010 || req !== 1'b0) begin
            $display("FAIL jump_reset pc %h addr %h req %b want 10000010 10000010 0", pc_cur, addr, req);
            errors++;
        end
        @(negedge clk);
        rst2_n = 1'b1;
        mpc = 32'h1000_0010; mcount = 32'h0;
        run_instr(32'h0800_0040, 0, 0, 0, 1, 1, 1'($urandom), 0);
        checks++;
        if (addr !== 32'h1000_0100) begin $display("FAIL jump_target addr %h want 10000100", addr); errors++; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        sel = 1'b0; rst1_n = 1'b0; rst2_n = 1'b0;
        ack = 1'b0; ex_done = 1'b0; jump = 1'b0; branch = 1'b0; alu_zero = 1'b0; rdata = '0;
        mpc = '0; mcount = '0;
        repeat (2) @(negedge clk);
        test_reset;
        test_sequential;
        test_branch;
        test_wait_states;
        test_pc_wrap;
        test_random;
        test_count_wrap;
        test_reset_mid_fetch;
        test_jump;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
